// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with valid/ready on every channel and on the output.
// The grant comes from an external select or from a rotating pointer that skips idle channels.

module mux_nto1_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] gnt,
  input  logic            gnt_vld,
  input  logic            load_en,
  input  logic            rst,
  output logic            ready
);
  assign ready = !rst && load_en && gnt_vld && (gnt == SELW'(IDX));
endmodule

module mux_nto1_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [SELW-1:0]      ptr, gnt, rr_gnt;
  logic                 rr_vld, man_vld, gnt_vld, load_en, xfer;
  logic [2**SELW-1:0]   valid_pad;

  assign load_en = !out_valid || out_ready;

  // Zero-padded so an out-of-range sel reads an idle channel.
  always_comb begin
    valid_pad          = '0;
    valid_pad[N-1:0]   = in_valid;
  end

  // First valid channel at or after ptr, wrapping at N.
  always_comb begin
    int idx;
    rr_vld = 1'b0;
    rr_gnt = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!rr_vld && in_valid[idx]) begin
        rr_vld = 1'b1;
        rr_gnt = SELW'(idx);
      end
    end
  end

  assign man_vld = (int'(sel) < N) && valid_pad[sel];
  assign gnt     = mode ? rr_gnt : sel;
  assign gnt_vld = mode ? rr_vld : man_vld;
  assign xfer    = !rst && load_en && gnt_vld;

  for (genvar k = 0; k < N; k++) begin : g_lane
    mux_nto1_lane #(.SELW(SELW), .IDX(k)) u_lane (
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .load_en (load_en),
      .rst     (rst),
      .ready   (in_ready[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
      out_ch    <= gnt;
      out_valid <= 1'b1;
      if (mode) ptr <= (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
